dm_ls_ctrl: RTL
===============

# dm_ls_ctrl

Parametrised, synchronous data memory for the MEM stage with a valid/ready request port and a configurable access latency. Supports word, halfword and byte loads and stores, with sign or zero extension on loads. Detects misaligned accesses and reports them instead of performing them. It replaces the combinational data memory: the pipeline stalls on `req_ready`/`rsp_valid` instead of relying on same-cycle reads.

## Interface
- `ADDR_WIDTH`, 10: word-address width; depth = 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 0: extra cycles between request accept and memory access (0..15).
- `NONE`/`WORD`/`HALF`/`BYTE`, 2'b00/01/10/11: `ls_size` encodings.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `ls_size` in 2: access size. `NONE` is never accepted and is treated as no request.
- `mem_write` in 1: 1 = store, 0 = load.
- `ext_op` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte address. Bits above ADDR_WIDTH+1 are ignored, so addresses wrap.
- `wdata` in 32: store data; the low 8/16/32 bits are used.
- `rsp_valid` out 1: one-cycle response pulse.
- `rdata` out 32: load result; 0 for stores and faults.
- `misalign` out 1: qualifies `rsp_valid`; the access was not performed.

## Operation
- **Word index:** `addr[ADDR_WIDTH+1:2]`. Byte lane: `addr[1:0]`; halfword lane: `addr[1]`. Little-endian, so lane 0 is bits [7:0].
- **Accept:** a request is accepted on a rising edge when `req_valid && req_ready && ls_size != NONE`. All inputs are captured into request registers at that edge. Inputs are don't-care afterwards.
- **Misalignment:** `WORD` with `addr[1:0] != 0`, or `HALF` with `addr[0] != 0`.
  - Memory is not read or written.
  - Response is `misalign=1`, `rdata=0`.
  - Latency is the same as a normal access.
- **Stores:** only the selected byte lanes of the addressed word are written. The other lanes are unchanged.
- **Loads:**
  - The selected lane is extended per `ext_op`: BYTE to 24 bits, HALF to 16 bits. WORD is returned unchanged.
  - Example: byte 0x80 gives 0xFFFFFF80 with `ext_op=1` and 0x00000080 with `ext_op=0`.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: `req_ready=1`. On accept, go to WAIT if `WAIT_CYCLES>0`, otherwise go to RESP with the access performed at the accept edge.
  - WAIT: `req_ready=0`. A counter loads `WAIT_CYCLES-1` on entry and decrements each cycle. At the edge where the counter is 0, perform the access and go to RESP.
  - RESP: `rsp_valid=1` for exactly one cycle with `rdata`/`misalign` valid. `req_ready=1`. An accept in this cycle follows the IDLE accept rules (back-to-back). Otherwise go to IDLE.
- **Ordering:** accesses execute strictly in accept order. A load following a store to the same word always observes the stored data.
- **Memory and reset:** memory contents are not cleared by reset. Simulation may preload them by `$readmemh` once at time 0 only, never on clock or reset edges.

## Timing
- **Reset values:** state=IDLE, `req_ready=1`, `rsp_valid=0`, `rdata=0`, `misalign=0`, counter=0.
- **Latency:** `rsp_valid` is high in the cycle starting WAIT_CYCLES+1 edges after the accept edge.
- **Throughput:** one request per WAIT_CYCLES+1 cycles with back-to-back acceptance in RESP.
- **Registered outputs:** `rdata` and `misalign` are registered. They hold their values while `rsp_valid=0`; consumers must qualify them with `rsp_valid`.
- **Reset mid-operation:**
  - An asserted `reset` in WAIT drops the pending request.
  - Its store is not committed.
  - No response is issued.
  - Outputs take their reset values immediately (asynchronous).
- **`req_valid` while busy:** `req_valid` asserted while `req_ready=0` is ignored. The requester must hold it until accepted.
- **Non-requests:** `ls_size=NONE` with `req_valid=1` is not accepted and changes no state.

## Test plan
- **Word store then load:** `WAIT_CYCLES=0`. Store word 0xDEADBEEF at 0x40, then load word at 0x40 -> `rsp_valid` 1 cycle after each accept; `rdata`=0xDEADBEEF on the load.
- **Byte lanes and extension:** store byte 0x80 at 0x43, then load byte at 0x43 with `ext_op=1` -> 0xFFFFFF80. Load byte with `ext_op=0` -> 0x00000080. Load word at 0x40 -> 0x80ADBEEF.
- **Halfword lane:** store halfword 0x1234 at 0x42 over 0xDEADBEEF, then load halfword at 0x42 with `ext_op=1` -> 0x00001234. Load word -> 0x1234BEEF.
- **Misaligned accesses:** load word at 0x41 and store halfword at 0x43 -> `misalign=1`, `rdata=0`. Word 0x40 is unchanged.
- **Wait latency and wrap:** `WAIT_CYCLES=3`, `ADDR_WIDTH=10`. Store at 0x1004 -> `req_ready` low for 3 cycles, `rsp_valid` 4 cycles after accept. Load at 0x0004 returns the stored value (wrap).
- **Reset mid-operation:** `WAIT_CYCLES=3`. Pulse `reset` low during WAIT of a store of 0x55 -> no `rsp_valid`, outputs reset. A later load of that address returns the old value.

Source files
------------

// File: rtl/dm_ls_ctrl_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The requester drives master; the memory controller is the slave.
interface dm_ls_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  ls_size;
   logic        mem_write;
   logic        ext_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        misalign;

   modport master (
      output req_valid,
      output ls_size,
      output mem_write,
      output ext_op,
      output addr,
      output wdata,
      input  req_ready,
      input  rsp_valid,
      input  rdata,
      input  misalign
   );

   modport slave (
      input  req_valid,
      input  ls_size,
      input  mem_write,
      input  ext_op,
      input  addr,
      input  wdata,
      output req_ready,
      output rsp_valid,
      output rdata,
      output misalign
   );
endinterface

// File: rtl/dm_ls_ctrl.sv
// MEM-stage data memory: valid/ready requests, configurable latency,
// byte/half/word access with load extension and misalign reporting.
module dm_ls_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input logic         clock,
   input logic         reset,
   dm_ls_ctrl_if.slave bus
);
   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] WORD = 2'b01;
   localparam logic [1:0] HALF = 2'b10;
   localparam logic [1:0] BYTE = 2'b11;

   localparam int BW    = ADDR_WIDTH + 2;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   typedef struct packed {
      logic [1:0]    size;
      logic          wr;
      logic          ext;
      logic [BW-1:0] addr;
      logic [31:0]   wdata;
   } req_t;

   state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic        mis_q, mis_d;

   req_t                  acc;
   logic                  accept;
   logic                  do_access;
   logic                  acc_mis;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [31:0]           acc_word;
   logic [7:0]            lane8;
   logic [15:0]           lane16;
   logic [31:0]           load_val;
   logic [31:0]           st_data;
   logic [3:0]            st_be;
   logic                  unused_addr;

   logic [31:0] mem [DEPTH];

   // Upper address bits are ignored so accesses wrap.
   assign unused_addr = ^bus.addr[31:BW];

   assign accept = reset && bus.req_valid && bus.req_ready &&
                   (bus.ls_size != NONE);

   always_comb begin
      req_d = req_q;
      if (accept) begin
         req_d.size  = bus.ls_size;
         req_d.wr    = bus.mem_write;
         req_d.ext   = bus.ext_op;
         req_d.addr  = bus.addr[BW-1:0];
         req_d.wdata = bus.wdata;
      end
   end

   // Zero latency uses the live request at the accept edge.
   always_comb begin
      do_access = 1'b0;
      acc       = req_q;
      if (WAIT_CYCLES == 0) begin
         do_access = accept;
         acc       = req_d;
      end else begin
         do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
      end
   end

   assign acc_idx  = acc.addr[BW-1:2];
   assign acc_word = mem[acc_idx];
   assign acc_mis  = ((acc.size == WORD) && (acc.addr[1:0] != 2'b00)) ||
                     ((acc.size == HALF) && acc.addr[0]);

   always_comb begin
      lane8    = '0;
      lane16   = '0;
      load_val = acc_word;
      st_be    = 4'b1111;
      st_data  = acc.wdata;
      case (acc.size)
         BYTE: begin
            lane8    = acc_word[{acc.addr[1:0], 3'b000} +: 8];
            load_val = {{24{acc.ext & lane8[7]}}, lane8};
            st_be    = 4'b0001 << acc.addr[1:0];
            st_data  = {4{acc.wdata[7:0]}};
         end
         HALF: begin
            lane16   = acc.addr[1] ? acc_word[31:16] : acc_word[15:0];
            load_val = {{16{acc.ext & lane16[15]}}, lane16};
            st_be    = acc.addr[1] ? 4'b1100 : 4'b0011;
            st_data  = {2{acc.wdata[15:0]}};
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      mis_d   = mis_q;
      if (do_access) begin
         mis_d   = acc_mis;
         rdata_d = (acc_mis || acc.wr) ? '0 : load_val;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_RESP: begin
            if (accept) begin
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q != S_WAIT);
      bus.rsp_valid = (state_q == S_RESP);
      bus.rdata     = rdata_q;
      bus.misalign  = mis_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   // Contents survive reset; only selected lanes are written.
   always_ff @(posedge clock) begin
      if (do_access && acc.wr && !acc_mis) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) begin
               mem[acc_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
         end
      end
   end
endmodule
